mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle sequencer for the mips32 datapath. Each instruction runs through FETCH/DECODE/EXEC/MEM/WB states. The block decodes opcode/funct from the instruction register and issues one-hot-per-cycle strobes to the PC, IR, register file and memory port. It drives the 3-bit ALU operation code. Memory wait-states are handled through a ready handshake.

## Interface
- Parameters: none.
- `clk` in 1: single clock, all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, sampled in EXEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_we` out 1: PC write strobe.
- `pc_src` out 2: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (jr).
- `ir_we` out 1: IR load strobe.
- `mem_req` out 1: memory access active.
- `mem_we` out 1: store.
- `mem_size` out 2: 00 = word, 01 = half, 10 = byte.
- `reg_we` out 1: register-file write.
- `reg_dst` out 2: 00 = rt, 01 = rd, 10 = $31.
- `wb_sel` out 2: 00 = ALU, 01 = memory, 10 = PC+4, 11 = imm<<16.
- `alu_src_b` out 1: 0 = rt, 1 = immediate.
- `alu_op` out 3: ALU code.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `state` out 3: FSM state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Outputs are Moore-style, decoded from `state` plus the IR fields.
- Strobes not listed for a state are 0.
- FETCH:
  - `mem_req`=1.
  - On `mem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=00, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: no strobes.
  - Recognised opcode: go to EXEC.
  - Unrecognised opcode or R-type funct: pulse `illegal`, go to FETCH.
- ALU codes: and 000, or 001, add 010, xor 011, shift-right (sra/srl) 100, sll 101, sub 110, slt/sltu 111.
- R-type (opcode 000000):
  - funct: and 00, or 01, xor 02, add 03, sub 04, slt 05, sra 06, srl 07, sll 08, sltu 09, jr 0A (hex).
  - EXEC: `alu_src_b`=0, `alu_op` per funct.
  - WB: `reg_we`=1, `reg_dst`=01, `wb_sel`=00.
  - jr: EXEC drives `pc_we`=1, `pc_src`=11, then returns to FETCH.
- I-type ALU (EXEC `alu_src_b`=1, then WB to rt with `wb_sel`=00):
  - andi 01: `alu_op`=000.
  - ori 02: `alu_op`=001.
  - xori 03: `alu_op`=011.
  - addi 04 / addiu 05: `alu_op`=010.
  - slti 06 / sltiu 07: `alu_op`=111.
- lui 0F: WB with `wb_sel`=11.
- Loads lw 23 / lh 21 / lb 20:
  - EXEC: `alu_op`=010, `alu_src_b`=1.
  - MEM: `mem_req`=1, `mem_size` per opcode.
  - WB: rt, `wb_sel`=01.
- Stores sw 2B / sb 28: EXEC as loads, MEM with `mem_we`=1, then FETCH.
- Branches beq 0E / bne 10:
  - EXEC: `alu_op`=110, `alu_src_b`=0.
  - `pc_we` = (`zero` for beq, !`zero` for bne), `pc_src`=01.
  - Then FETCH.
- j 11: EXEC `pc_we`=1, `pc_src`=10.
- jal 12: as j, plus `reg_we`=1, `reg_dst`=10, `wb_sel`=10 in the same cycle.
- MEM leaves only when `mem_ready`=1. While waiting, `mem_req`, `mem_we` and `mem_size` hold steady.

## Timing
- Reset:
  - `state`=FETCH.
  - While `reset` is high, every strobe (`pc_we`, `ir_we`, `mem_req`, `mem_we`, `reg_we`, `illegal`) is 0.
  - All other outputs are 0 during reset.
- Reset asserted in any state, including a MEM wait, aborts the instruction. No write strobe fires in that cycle or after.
- Zero-wait latencies (cycles):
  - R/I-ALU/lui: 4.
  - Load: 5.
  - Store: 4.
  - Branch/j/jal/jr: 3.
  - Illegal: 2.
- Each cycle `mem_ready` is low in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored outside FETCH/MEM.
- `pc_we` and `reg_we` are asserted for exactly one cycle per instruction. The single-cycle PC-update/writeback in EXEC (jr, j, jal, taken branch) is the exception path.
- The PC+4 used by jal is the value latched during FETCH.

## Configuration
- `MC_WAITSTATE_EN` defined: `mem_ready` handshake as above.
- Undefined: `mem_ready` is ignored and treated as constant 1. FETCH and MEM each last exactly one cycle. The port remains present.

## Test plan
- Reset held 3 cycles mid-MEM of lw → all strobes 0, `state`=0 on the first cycle after release.
- add (opcode 00, funct 03), `mem_ready`=1 → states 0,1,2,4; `alu_op`=010 in EXEC; `reg_we`=1 with `reg_dst`=01 in cycle 4.
- lw with `mem_ready` low 2 cycles in MEM → 7-cycle instruction; `mem_size`=00 held; `reg_we` with `wb_sel`=01 once.
- beq with `zero`=1, then bne with `zero`=1 → first: `pc_we`=1, `pc_src`=01 in EXEC; second: `pc_we`=0; both 3 cycles.
- jal (12) → EXEC: `pc_we`=1, `pc_src`=10, `reg_we`=1, `reg_dst`=10, `wb_sel`=10.
- opcode 3F → `illegal` pulses in DECODE, FETCH next cycle, no `reg_we`/`mem_we`.

Source files
------------

// File: rtl/mc_control_if.sv
// Bus between the mips32 multi-cycle sequencer and its datapath.
// master: the sequencer (mc_control); slave: the datapath side.
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, pc_src, ir_we, mem_req, mem_we, mem_size,
               reg_we, reg_dst, wb_sel, alu_src_b, alu_op, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, pc_src, ir_we, mem_req, mem_we, mem_size,
               reg_we, reg_dst, wb_sel, alu_src_b, alu_op, illegal, state
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for mips32.
// Outputs are decoded from the state register plus the IR opcode/funct.
// Build option: define MC_WAITSTATE_EN to honour the mem_ready handshake in
// FETCH and MEM; without it mem_ready is ignored and both states last one cycle.
module mc_control (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_JR, C_IALU, C_LUI, C_LOAD, C_STORE,
        C_BEQ, C_BNE, C_J, C_JAL
    } cls_t;

    state_t     state_reg, state_next;
    cls_t       cls;
    logic [2:0] alu_code;
    logic [1:0] size_code;
    logic       ready;

`ifdef MC_WAITSTATE_EN
    assign ready = bus.mem_ready;
`else
    // Port kept for a uniform datapath interface; accesses always complete.
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign ready = 1'b1;
`endif

    // Instruction decode: class, ALU code and memory access width.
    always_comb begin
        cls       = C_ILL;
        alu_code  = 3'b000;
        size_code = 2'b00;
        case (bus.opcode)
            6'h00: begin
                cls = C_RALU;
                case (bus.funct)
                    6'h00: alu_code = 3'b000;
                    6'h01: alu_code = 3'b001;
                    6'h02: alu_code = 3'b011;
                    6'h03: alu_code = 3'b010;
                    6'h04: alu_code = 3'b110;
                    6'h05: alu_code = 3'b111;
                    6'h06: alu_code = 3'b100;
                    6'h07: alu_code = 3'b100;
                    6'h08: alu_code = 3'b101;
                    6'h09: alu_code = 3'b111;
                    6'h0A: cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            6'h01: begin cls = C_IALU; alu_code = 3'b000; end
            6'h02: begin cls = C_IALU; alu_code = 3'b001; end
            6'h03: begin cls = C_IALU; alu_code = 3'b011; end
            6'h04,
            6'h05: begin cls = C_IALU; alu_code = 3'b010; end
            6'h06,
            6'h07: begin cls = C_IALU; alu_code = 3'b111; end
            6'h0F: cls = C_LUI;
            6'h23: begin cls = C_LOAD;  alu_code = 3'b010; size_code = 2'b00; end
            6'h21: begin cls = C_LOAD;  alu_code = 3'b010; size_code = 2'b01; end
            6'h20: begin cls = C_LOAD;  alu_code = 3'b010; size_code = 2'b10; end
            6'h2B: begin cls = C_STORE; alu_code = 3'b010; size_code = 2'b00; end
            6'h28: begin cls = C_STORE; alu_code = 3'b010; size_code = 2'b10; end
            6'h0E: begin cls = C_BEQ;   alu_code = 3'b110; end
            6'h10: begin cls = C_BNE;   alu_code = 3'b110; end
            6'h11: cls = C_J;
            6'h12: cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end

    // State register; reset aborts any instruction, including a MEM wait.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= FETCH;
        else       state_reg <= state_next;
    end

    // Next-state and Moore outputs; reset forces every output to 0.
    always_comb begin
        state_next    = state_reg;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'b00;
        bus.ir_we     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_size  = 2'b00;
        bus.reg_we    = 1'b0;
        bus.reg_dst   = 2'b00;
        bus.wb_sel    = 2'b00;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 3'b000;
        bus.illegal   = 1'b0;
        bus.state     = state_reg;
        case (state_reg)
            FETCH: begin
                bus.mem_req = 1'b1;
                if (ready) begin
                    bus.ir_we  = 1'b1;
                    bus.pc_we  = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (cls == C_ILL) begin
                    bus.illegal = 1'b1;
                    state_next  = FETCH;
                end else begin
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                bus.alu_op    = alu_code;
                bus.alu_src_b = (cls == C_IALU) || (cls == C_LOAD) || (cls == C_STORE);
                case (cls)
                    C_RALU, C_IALU, C_LUI: state_next = WB;
                    C_LOAD, C_STORE:       state_next = MEM;
                    C_BEQ: begin
                        bus.pc_we  = bus.zero;
                        bus.pc_src = 2'b01;
                        state_next = FETCH;
                    end
                    C_BNE: begin
                        bus.pc_we  = !bus.zero;
                        bus.pc_src = 2'b01;
                        state_next = FETCH;
                    end
                    C_J: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'b10;
                        state_next = FETCH;
                    end
                    C_JAL: begin
                        bus.pc_we   = 1'b1;
                        bus.pc_src  = 2'b10;
                        bus.reg_we  = 1'b1;
                        bus.reg_dst = 2'b10;
                        bus.wb_sel  = 2'b10;
                        state_next  = FETCH;
                    end
                    C_JR: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'b11;
                        state_next = FETCH;
                    end
                    default: state_next = FETCH;
                endcase
            end
            MEM: begin
                // Driven only from state and IR, so steady across wait cycles.
                bus.mem_req  = 1'b1;
                bus.mem_we   = (cls == C_STORE);
                bus.mem_size = size_code;
                if (ready) state_next = (cls == C_LOAD) ? WB : FETCH;
            end
            WB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = (cls == C_RALU) ? 2'b01 : 2'b00;
                bus.wb_sel  = (cls == C_LOAD) ? 2'b01 :
                              (cls == C_LUI)  ? 2'b11 : 2'b00;
                state_next  = FETCH;
            end
            default: state_next = FETCH;
        endcase
        if (reset) begin
            bus.pc_we     = 1'b0;
            bus.pc_src    = 2'b00;
            bus.ir_we     = 1'b0;
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_size  = 2'b00;
            bus.reg_we    = 1'b0;
            bus.reg_dst   = 2'b00;
            bus.wb_sel    = 2'b00;
            bus.alu_src_b = 1'b0;
            bus.alu_op    = 3'b000;
            bus.illegal   = 1'b0;
            bus.state     = FETCH;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle state and output-vector checks
// for each instruction class, wait-states, illegal decode and mid-MEM reset.
module tb_mc_control;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc_cnt;
    int   t0;

    mc_control_if bus ();

    mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

`ifdef MC_WAITSTATE_EN
    localparam int LW_LEN = 7;
`else
    localparam int LW_LEN = 5;
`endif

    // Output vector: pc_we, pc_src, ir_we, mem_req, mem_we, mem_size,
    // reg_we, reg_dst, wb_sel, alu_src_b, alu_op, illegal
    logic [17:0] obs;
    assign obs = {bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_req, bus.mem_we,
                  bus.mem_size, bus.reg_we, bus.reg_dst, bus.wb_sel,
                  bus.alu_src_b, bus.alu_op, bus.illegal};

    function automatic logic [17:0] mk(
        input logic pw, input logic [1:0] ps, input logic iw, input logic mr,
        input logic mw, input logic [1:0] ms, input logic rw, input logic [1:0] rd,
        input logic [1:0] ws, input logic asb, input logic [2:0] ao, input logic il);
        return {pw, ps, iw, mr, mw, ms, rw, rd, ws, asb, ao, il};
    endfunction

    logic [17:0] v_fetch, v_fwait, v_idle, v_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check one cycle (state and outputs), then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [17:0] exp_vec);
        #1;
        check({tag, ".state"}, {29'd0, bus.state}, {29'd0, exp_state});
        check({tag, ".out"}, {14'd0, obs}, {14'd0, exp_vec});
        $display("cycle %0d %s state=%0d out=%h", cyc_cnt, tag, bus.state, obs);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_phase(input string tag, input int waits);
`ifdef MC_WAITSTATE_EN
        for (int i = 0; i < waits; i++) begin
            bus.mem_ready = 1'b0;
            cyc({tag, ".fwait"}, 3'd0, v_fwait);
        end
        bus.mem_ready = 1'b1;
`else
        bus.mem_ready = (waits == 0);
`endif
        cyc({tag, ".fetch"}, 3'd0, v_fetch);
        bus.mem_ready = 1'b1;
    endtask

    task automatic mem_phase(input string tag, input int waits, input logic [17:0] v);
`ifdef MC_WAITSTATE_EN
        for (int i = 0; i < waits; i++) begin
            bus.mem_ready = 1'b0;
            cyc({tag, ".mwait"}, 3'd3, v);
        end
        bus.mem_ready = 1'b1;
`else
        bus.mem_ready = (waits == 0);
`endif
        cyc({tag, ".mem"}, 3'd3, v);
        bus.mem_ready = 1'b1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc_cnt = 0;
        v_fetch = mk(1, 2'b00, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0);
        v_fwait = mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0);
        v_idle  = 18'd0;
        v_ill   = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 1);

        reset = 1'b1;
        bus.opcode = 6'h00;
        bus.funct = 6'h03;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 3'd0, v_idle);
        reset = 1'b0;

        // add
        set_ir(6'h00, 6'h03);
        fetch_phase("add", 0);
        cyc("add.dec", 3'd1, v_idle);
        cyc("add.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b010, 0));
        cyc("add.wb", 3'd4, mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'b000, 0));

        // sra
        set_ir(6'h00, 6'h06);
        fetch_phase("sra", 0);
        cyc("sra.dec", 3'd1, v_idle);
        cyc("sra.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b100, 0));
        cyc("sra.wb", 3'd4, mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'b000, 0));

        // andi
        set_ir(6'h01, 6'h00);
        fetch_phase("andi", 0);
        cyc("andi.dec", 3'd1, v_idle);
        cyc("andi.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 0));
        cyc("andi.wb", 3'd4, mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 3'b000, 0));

        // lui
        set_ir(6'h0F, 6'h00);
        fetch_phase("lui", 0);
        cyc("lui.dec", 3'd1, v_idle);
        cyc("lui.exec", 3'd2, v_idle);
        cyc("lui.wb", 3'd4, mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b11, 0, 3'b000, 0));

        // lw with two MEM wait cycles
        set_ir(6'h23, 6'h00);
        t0 = cyc_cnt;
        fetch_phase("lw", 0);
        cyc("lw.dec", 3'd1, v_idle);
        cyc("lw.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 0));
        mem_phase("lw", 2, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0));
        cyc("lw.wb", 3'd4, mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 3'b000, 0));
        check("lw.len", cyc_cnt - t0, LW_LEN);

        // lh with one FETCH wait cycle
        set_ir(6'h21, 6'h00);
        fetch_phase("lh", 1);
        cyc("lh.dec", 3'd1, v_idle);
        cyc("lh.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 0));
        mem_phase("lh", 0, mk(0, 2'b00, 0, 1, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'b000, 0));
        cyc("lh.wb", 3'd4, mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 3'b000, 0));

        // sb
        set_ir(6'h28, 6'h00);
        fetch_phase("sb", 0);
        cyc("sb.dec", 3'd1, v_idle);
        cyc("sb.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 0));
        mem_phase("sb", 1, mk(0, 2'b00, 0, 1, 1, 2'b10, 0, 2'b00, 2'b00, 0, 3'b000, 0));

        // beq taken, bne not taken, bne taken
        set_ir(6'h0E, 6'h00);
        bus.zero = 1'b1;
        fetch_phase("beq", 0);
        cyc("beq.dec", 3'd1, v_idle);
        cyc("beq.exec", 3'd2, mk(1, 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b110, 0));
        set_ir(6'h10, 6'h00);
        fetch_phase("bne1", 0);
        cyc("bne1.dec", 3'd1, v_idle);
        cyc("bne1.exec", 3'd2, mk(0, 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b110, 0));
        bus.zero = 1'b0;
        fetch_phase("bne0", 0);
        cyc("bne0.dec", 3'd1, v_idle);
        cyc("bne0.exec", 3'd2, mk(1, 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b110, 0));

        // j, jal, jr
        set_ir(6'h11, 6'h00);
        fetch_phase("j", 0);
        cyc("j.dec", 3'd1, v_idle);
        cyc("j.exec", 3'd2, mk(1, 2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0));
        set_ir(6'h12, 6'h00);
        fetch_phase("jal", 0);
        cyc("jal.dec", 3'd1, v_idle);
        cyc("jal.exec", 3'd2, mk(1, 2'b10, 0, 0, 0, 2'b00, 1, 2'b10, 2'b10, 0, 3'b000, 0));
        set_ir(6'h00, 6'h0A);
        fetch_phase("jr", 0);
        cyc("jr.dec", 3'd1, v_idle);
        cyc("jr.exec", 3'd2, mk(1, 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0));

        // illegal opcode, then illegal R-type funct
        set_ir(6'h3F, 6'h00);
        t0 = cyc_cnt;
        fetch_phase("ill", 0);
        cyc("ill.dec", 3'd1, v_ill);
        check("ill.len", cyc_cnt - t0, 2);
        set_ir(6'h00, 6'h20);
        fetch_phase("illr", 0);
        cyc("illr.dec", 3'd1, v_ill);

        // reset held three cycles while in MEM of lw
        set_ir(6'h23, 6'h00);
        fetch_phase("rlw", 0);
        cyc("rlw.dec", 3'd1, v_idle);
        cyc("rlw.exec", 3'd2, mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 0));
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        cyc("rlw.rst0", 3'd0, v_idle);
        cyc("rlw.rst1", 3'd0, v_idle);
        cyc("rlw.rst2", 3'd0, v_idle);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("rlw.after", 3'd0, v_fetch);
        cyc("rlw.dec2", 3'd1, v_idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
